// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Opcodes, FSM states and counter sizing live here.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH);

  // Code 7 is reserved and decodes as no operation.
  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  function automatic logic mdu_op_signed(input logic [2:0] op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the multiply (shift-add) or divide (restoring) datapath.
// The accumulator holds {product_hi, multiplier} or {remainder, dividend/quotient}.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_b};
    // Partial remainder shifted left with the next dividend bit brought in.
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, i_b};
    o_acc    = {1'b0, i_acc[2*WIDTH-1:1]};
    if (i_is_div) begin
      if (w_diff[WIDTH]) begin
        o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end else begin
        o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO; WIDTH iterations plus one sign-fix cycle.
// busy lets the hazard unit stall HI/LO readers and further mult/div ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  mdu_state_t         r_state;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_srca;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_div0;
  logic               r_done;

  logic               w_go;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  always_comb begin
    w_go     = start && !flush && (r_state == IDLE);
    w_is_mul = (op == MULT) || (op == MULTU);
    w_is_div = (op == DIV) || (op == DIVU);
    w_accept = w_go && (w_is_mul || w_is_div);
    w_a_neg  = mdu_op_signed(op) && srca[WIDTH-1];
    w_b_neg  = mdu_op_signed(op) && srcb[WIDTH-1];
    w_a_mag  = w_a_neg ? (~srca + 1'b1) : srca;
    w_b_mag  = w_b_neg ? (~srcb + 1'b1) : srcb;
  end

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_is_div(r_is_div),
    .i_acc   (r_acc),
    .i_b     (r_b),
    .o_acc   (w_acc_next)
  );

  // Sign correction; divide-by-zero bypasses it to return all-ones / the raw dividend.
  always_comb begin
    w_prod   = r_qneg ? (~r_acc + 1'b1) : r_acc;
    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_hi_fix = r_srca;
        w_lo_fix = '1;
      end else begin
        w_hi_fix = r_rneg ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
        w_lo_fix = r_qneg ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_srca   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              // Multiplier (or dividend) sits in the low half and is consumed LSB/MSB first.
              r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              r_b      <= w_is_div ? w_b_mag : w_a_mag;
              r_srca   <= srca;
              r_is_div <= w_is_div;
              r_qneg   <= w_a_neg ^ w_b_neg;
              r_rneg   <= w_a_neg;
              r_div0   <= w_is_div && (srcb == '0);
              r_cnt    <= '0;
              r_state  <= RUN;
            end else if (w_go && (op == MTHI)) begin
              r_hi <= srca;
            end else if (w_go && (op == MTLO)) begin
              r_lo <= srca;
            end
          end
          RUN: begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LastCnt) begin
              r_state <= FIX;
            end
          end
          FIX: begin
            r_hi    <= w_hi_fix;
            r_lo    <= w_lo_fix;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
